// File: rtl/dataflow_stream_if.sv
// Handshake bundle for the loop-index generator: three config streams in,
// index and will-continue streams out.
interface dataflow_stream_if #(
    parameter int WIDTH = 32
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] start_data;
    logic             step_valid;
    logic             step_ready;
    logic [WIDTH-1:0] step_data;
    logic             bound_valid;
    logic             bound_ready;
    logic [WIDTH-1:0] bound_data;
    logic             idx_valid;
    logic             idx_ready;
    logic [WIDTH-1:0] idx_data;
    logic             wc_valid;
    logic             wc_ready;
    logic             wc_data;

    // Generator side
    modport slave (
        input  start_valid, start_data, step_valid, step_data, bound_valid, bound_data,
        output start_ready, step_ready, bound_ready,
        output idx_valid, idx_data, wc_valid, wc_data,
        input  idx_ready, wc_ready
    );

    // Producer / consumer side
    modport master (
        output start_valid, start_data, step_valid, step_data, bound_valid, bound_data,
        input  start_ready, step_ready, bound_ready,
        input  idx_valid, idx_data, wc_valid, wc_data,
        output idx_ready, wc_ready
    );
endinterface

// File: rtl/dataflow_stream.sv
// Loop-index generator: joins {start,step,bound}, emits idx per iteration and a will-continue token on wc.
// Latency: first idx/wc valid 1 cycle after config accept; one iteration per cycle at full throughput.
// Backpressure: idx and wc fork eagerly; each holds valid until ready, iteration advances when both have fired.
module dataflow_stream #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    dataflow_stream_if.slave s
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cur, cur_nxt;
    logic [WIDTH-1:0] step_r, step_nxt;
    logic [WIDTH-1:0] bound_r, bound_nxt;
    logic             idx_done, idx_done_nxt;
    logic             wc_done, wc_done_nxt;
    logic             cond;
    logic             cfg_all;
    logic             idx_fire;
    logic             wc_fire;

    assign cond    = SIGNED ? ($signed(cur) < $signed(bound_r)) : (cur < bound_r);
    assign cfg_all = s.start_valid & s.step_valid & s.bound_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cur      <= '0;
            step_r   <= '0;
            bound_r  <= '0;
            idx_done <= 1'b0;
            wc_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur      <= cur_nxt;
            step_r   <= step_nxt;
            bound_r  <= bound_nxt;
            idx_done <= idx_done_nxt;
            wc_done  <= wc_done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cur_nxt       = cur;
        step_nxt      = step_r;
        bound_nxt     = bound_r;
        idx_done_nxt  = idx_done;
        wc_done_nxt   = wc_done;
        s.start_ready = 1'b0;
        s.step_ready  = 1'b0;
        s.bound_ready = 1'b0;
        s.idx_valid   = 1'b0;
        s.idx_data    = '0;
        s.wc_valid    = 1'b0;
        s.wc_data     = 1'b0;
        idx_fire      = 1'b0;
        wc_fire       = 1'b0;

        unique case (state)
            S_IDLE: begin
                // Each ready depends only on the other two valids, so nothing is taken until all three are present
                s.start_ready = s.step_valid & s.bound_valid;
                s.step_ready  = s.start_valid & s.bound_valid;
                s.bound_ready = s.start_valid & s.step_valid;
                if (cfg_all) begin
                    cur_nxt   = s.start_data;
                    step_nxt  = s.step_data;
                    bound_nxt = s.bound_data;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                s.wc_valid  = !wc_done;
                s.wc_data   = cond;
                s.idx_valid = cond & !idx_done;
                s.idx_data  = cur;
                idx_fire    = s.idx_valid & s.idx_ready;
                wc_fire     = s.wc_valid & s.wc_ready;
                if (cond) begin
                    if ((idx_fire | idx_done) && (wc_fire | wc_done)) begin
                        cur_nxt      = cur + step_r;
                        idx_done_nxt = 1'b0;
                        wc_done_nxt  = 1'b0;
                    end else begin
                        idx_done_nxt = idx_done | idx_fire;
                        wc_done_nxt  = wc_done | wc_fire;
                    end
                end else if (wc_fire) begin
                    state_nxt    = S_IDLE;
                    idx_done_nxt = 1'b0;
                    wc_done_nxt  = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dataflow_stream.sv
// Directed bench: a signed and an unsigned generator share stimulus; tokens are logged at negedge.
module tb_dataflow_stream;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dataflow_stream_if #(.WIDTH(W)) ifs ();
    dataflow_stream_if #(.WIDTH(W)) ifu ();

    dataflow_stream #(.WIDTH(W), .SIGNED(1'b1)) u_dut (.clk(clk), .rst_n(rst_n), .s(ifs));
    dataflow_stream #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (.clk(clk), .rst_n(rst_n), .s(ifu));

    assign ifu.start_valid = ifs.start_valid;
    assign ifu.start_data  = ifs.start_data;
    assign ifu.step_valid  = ifs.step_valid;
    assign ifu.step_data   = ifs.step_data;
    assign ifu.bound_valid = ifs.bound_valid;
    assign ifu.bound_data  = ifs.bound_data;
    assign ifu.idx_ready   = ifs.idx_ready;
    assign ifu.wc_ready    = ifs.wc_ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;

    logic [W-1:0] idx_q[$], wc_q[$], uidx_q[$], uwc_q[$], exp_q[$];
    int           idx_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifs.idx_valid && ifs.idx_ready) begin
            idx_q.push_back(ifs.idx_data);
            idx_cyc.push_back(cyc);
        end
        if (ifs.wc_valid && ifs.wc_ready) wc_q.push_back(W'(ifs.wc_data));
        if (ifu.idx_valid && ifu.idx_ready) uidx_q.push_back(ifu.idx_data);
        if (ifu.wc_valid && ifu.wc_ready) uwc_q.push_back(W'(ifu.wc_data));
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input logic [W-1:0] q[$], input logic [W-1:0] e[$]);
        chk({tag, "_len"}, q.size(), e.size());
        for (int i = 0; i < e.size() && i < q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), q[i], e[i]);
    endtask

    task automatic set_exp(input int n, input logic [W-1:0] a, b, c, d);
        exp_q.delete();
        if (n > 0) exp_q.push_back(a);
        if (n > 1) exp_q.push_back(b);
        if (n > 2) exp_q.push_back(c);
        if (n > 3) exp_q.push_back(d);
    endtask

    task automatic clear_q();
        idx_q.delete(); wc_q.delete(); uidx_q.delete(); uwc_q.delete(); idx_cyc.delete();
    endtask

    task automatic step1();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cfg(input logic [W-1:0] st, input logic [W-1:0] sp, input logic [W-1:0] bd);
        logic ok;
        ok = 1'b0;
        ifs.start_valid = 1'b1; ifs.start_data = st;
        ifs.step_valid  = 1'b1; ifs.step_data  = sp;
        ifs.bound_valid = 1'b1; ifs.bound_data = bd;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifs.start_ready && ifs.step_ready && ifs.bound_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
                break;
            end
        end
        chk("cfg_accept", ok, 1);
        step1();
        ifs.start_valid = 1'b0;
        ifs.step_valid  = 1'b0;
        ifs.bound_valid = 1'b0;
    endtask

    // Waits for the wc=0 token, then expects idle on the following cycle
    task automatic wait_end(input string tag, input int lim);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (ifs.wc_valid && ifs.wc_ready && ifs.wc_data == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_end_seen"}, ok, 1);
        @(negedge clk);
        chk({tag, "_idle_idx_valid"}, ifs.idx_valid, 0);
        chk({tag, "_idle_wc_valid"}, ifs.wc_valid, 0);
        step1();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ifs.start_valid = 1'b0; ifs.start_data = '0;
        ifs.step_valid  = 1'b0; ifs.step_data  = '0;
        ifs.bound_valid = 1'b0; ifs.bound_data = '0;
        ifs.idx_ready   = 1'b0;
        ifs.wc_ready    = 1'b0;

        @(negedge clk);
        chk("rst_idx_valid", ifs.idx_valid, 0);
        chk("rst_wc_valid", ifs.wc_valid, 0);
        chk("rst_idx_data", ifs.idx_data, 0);
        chk("rst_wc_data", ifs.wc_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step1();

        // Basic loop 0..2
        ifs.idx_ready = 1'b1; ifs.wc_ready = 1'b1;
        clear_q();
        send_cfg(32'd0, 32'd1, 32'd3);
        wait_end("t1", 20);
        set_exp(3, 32'd0, 32'd1, 32'd2, 32'd0);
        chk_q("t1_idx", idx_q, exp_q);
        set_exp(4, 32'd1, 32'd1, 32'd1, 32'd0);
        chk_q("t1_wc", wc_q, exp_q);
        if (idx_cyc.size() == 3) begin
            chk("t1_first_latency", idx_cyc[0] - acc_cyc, 1);
            chk("t1_back_to_back", idx_cyc[2] - idx_cyc[0], 2);
        end

        // Zero trip
        clear_q();
        send_cfg(32'd5, 32'd1, 32'd5);
        wait_end("t2", 20);
        set_exp(0, 0, 0, 0, 0);
        chk_q("t2_idx", idx_q, exp_q);
        set_exp(1, 32'd0, 0, 0, 0);
        chk_q("t2_wc", wc_q, exp_q);

        // Fork backpressure: idx stalled 3 cycles, wc free-running
        clear_q();
        ifs.idx_ready = 1'b0;
        send_cfg(32'd0, 32'd2, 32'd6);
        @(negedge clk);
        chk("t3_wc_first_valid", ifs.wc_valid, 1);
        chk("t3_wc_first_data", ifs.wc_data, 1);
        step1();
        @(negedge clk);
        chk("t3_wc_done_hold", ifs.wc_valid, 0);
        chk("t3_idx_hold_valid", ifs.idx_valid, 1);
        chk("t3_idx_hold_data", ifs.idx_data, 0);
        step1();
        step1();
        ifs.idx_ready = 1'b1;
        wait_end("t3", 20);
        set_exp(3, 32'd0, 32'd2, 32'd4, 0);
        chk_q("t3_idx", idx_q, exp_q);
        set_exp(4, 32'd1, 32'd1, 32'd1, 32'd0);
        chk_q("t3_wc", wc_q, exp_q);

        // Signed vs unsigned compare of -2 < 1
        clear_q();
        send_cfg(32'hFFFF_FFFE, 32'd1, 32'd1);
        wait_end("t4", 20);
        set_exp(3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 0);
        chk_q("t4_idx", idx_q, exp_q);
        set_exp(4, 32'd1, 32'd1, 32'd1, 32'd0);
        chk_q("t4_wc", wc_q, exp_q);
        set_exp(0, 0, 0, 0, 0);
        chk_q("t4u_idx", uidx_q, exp_q);
        set_exp(1, 32'd0, 0, 0, 0);
        chk_q("t4u_wc", uwc_q, exp_q);

        // Join: bound withheld for 4 cycles
        clear_q();
        ifs.start_valid = 1'b1; ifs.start_data = 32'd10;
        ifs.step_valid  = 1'b1; ifs.step_data  = 32'd3;
        ifs.bound_data  = 32'd16;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_start_ready", ifs.start_ready, 0);
            chk("t5_step_ready", ifs.step_ready, 0);
            chk("t5_bound_ready", ifs.bound_ready, 1);
            chk("t5_no_wc", ifs.wc_valid, 0);
            step1();
        end
        ifs.bound_valid = 1'b1;
        @(negedge clk);
        chk("t5_join_all", {ifs.start_ready, ifs.step_ready, ifs.bound_ready}, 3'b111);
        step1();
        ifs.start_valid = 1'b0; ifs.step_valid = 1'b0; ifs.bound_valid = 1'b0;
        wait_end("t5", 20);
        set_exp(2, 32'd10, 32'd13, 0, 0);
        chk_q("t5_idx", idx_q, exp_q);
        set_exp(3, 32'd1, 32'd1, 32'd0, 0);
        chk_q("t5_wc", wc_q, exp_q);

        // Reset while idx=1 is pending
        clear_q();
        send_cfg(32'd0, 32'd1, 32'd10);
        step1();
        ifs.idx_ready = 1'b0;
        @(negedge clk);
        chk("t6_idx1_valid", ifs.idx_valid, 1);
        chk("t6_idx1_data", ifs.idx_data, 1);
        step1();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_idx_valid", ifs.idx_valid, 0);
        chk("t6_rst_wc_valid", ifs.wc_valid, 0);
        chk("t6_rst_idx_data", ifs.idx_data, 0);
        set_exp(1, 32'd0, 0, 0, 0);
        chk_q("t6_pre_idx", idx_q, exp_q);
        set_exp(2, 32'd1, 32'd1, 0, 0);
        chk_q("t6_pre_wc", wc_q, exp_q);
        step1();
        rst_n = 1'b1;
        ifs.idx_ready = 1'b1;
        clear_q();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_idle_idx", ifs.idx_valid, 0);
            chk("t6_idle_wc", ifs.wc_valid, 0);
            step1();
        end
        send_cfg(32'd7, 32'd1, 32'd8);
        wait_end("t6", 20);
        set_exp(1, 32'd7, 0, 0, 0);
        chk_q("t6_idx", idx_q, exp_q);
        set_exp(2, 32'd1, 32'd0, 0, 0);
        chk_q("t6_wc", wc_q, exp_q);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
